// File: rtl/qlf_k6n10_seg_adder_pipe_if.sv
// Operand/result bundle for the segmented adder pipe, with valid/ready on both sides.
// master drives operands and out_ready; slave is the adder.
interface qlf_k6n10_seg_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x;
  logic             co;
  logic             ov;

  modport master (
    output in_valid, a, b, bi, ci, out_ready,
    input  in_ready, out_valid, y, x, co, ov
  );

  modport slave (
    input  in_valid, a, b, bi, ci, out_ready,
    output in_ready, out_valid, y, x, co, ov
  );
endinterface

// File: rtl/qlf_k6n10_seg_adder_pipe.sv
// Carry-segmented add/sub: one SEG-bit chain per stage, registered carry between stages.
// Latency NSEG cycles, one beat per cycle; a stalled output freezes the whole pipe (in_ready = ~out_valid | out_ready).
module qlf_k6n10_seg_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  qlf_k6n10_seg_adder_pipe_if.slave     io
);

  localparam int NSEG = (WIDTH + SEG - 1) / SEG;
  localparam int PW   = NSEG * SEG;
  localparam int LW   = WIDTH - (NSEG - 1) * SEG;
  localparam int LAST = NSEG - 1;

  logic             adv;
  logic             acc;
  logic [WIDTH-1:0] bb_in;
  logic [PW-1:0]    a_pad;
  logic [PW-1:0]    bb_pad;

  // Rank k holds the beat after segment k has been added; rank LAST is the output register.
  logic             v_q  [NSEG];
  logic [PW-1:0]    a_q  [NSEG];
  logic [PW-1:0]    bb_q [NSEG];
  logic [PW-1:0]    s_q  [NSEG];
  logic [WIDTH-1:0] x_q  [NSEG];
  logic             c_q  [NSEG];
  logic             ov_q;

  logic             vin     [NSEG];
  logic [PW-1:0]    op_a    [NSEG];
  logic [PW-1:0]    op_b    [NSEG];
  logic [PW-1:0]    s_in    [NSEG];
  logic [PW-1:0]    s_out   [NSEG];
  logic [WIDTH-1:0] x_in    [NSEG];
  logic             cin     [NSEG];
  logic             cout    [NSEG];
  logic [SEG:0]     seg_sum [NSEG];
  logic             ov_nxt;

  assign adv         = ~v_q[LAST] | io.out_ready;
  assign acc         = io.in_valid & adv;
  assign io.in_ready = adv;

  assign bb_in  = io.bi ? ~io.b : io.b;
  assign a_pad  = PW'(io.a);
  assign bb_pad = PW'(bb_in);

  always_comb begin
    vin[0]  = acc;
    op_a[0] = a_pad;
    op_b[0] = bb_pad;
    s_in[0] = '0;
    x_in[0] = io.a ^ bb_in;
    cin[0]  = io.ci;
    for (int k = 1; k < NSEG; k++) begin
      vin[k]  = v_q[k-1];
      op_a[k] = a_q[k-1];
      op_b[k] = bb_q[k-1];
      s_in[k] = s_q[k-1];
      x_in[k] = x_q[k-1];
      cin[k]  = c_q[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      seg_sum[k] = {1'b0, op_a[k][k*SEG +: SEG]} + {1'b0, op_b[k][k*SEG +: SEG]}
                 + (SEG+1)'(cin[k]);
      s_out[k] = s_in[k];
      s_out[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      // Operands are zero-padded above WIDTH, so a short last segment carries out at bit LW.
      cout[k] = (k == LAST) ? seg_sum[k][LW] : seg_sum[k][SEG];
    end
    ov_nxt = op_a[LAST][WIDTH-1] ^ op_b[LAST][WIDTH-1] ^ s_out[LAST][WIDTH-1] ^ cout[LAST];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        bb_q[k] <= '0;
        s_q[k]  <= '0;
        x_q[k]  <= '0;
        c_q[k]  <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k] <= vin[k];
        if (vin[k]) begin
          a_q[k]  <= op_a[k];
          bb_q[k] <= op_b[k];
          s_q[k]  <= s_out[k];
          x_q[k]  <= x_in[k];
          c_q[k]  <= cout[k];
        end
      end
      if (vin[LAST]) begin
        ov_q <= ov_nxt;
      end
    end
  end

  assign io.out_valid = v_q[LAST];
  assign io.y         = s_q[LAST][WIDTH-1:0];
  assign io.x         = x_q[LAST];
  assign io.co        = c_q[LAST];
  assign io.ov        = ov_q;

endmodule

// File: doc/qlf_k6n10_seg_adder_pipe.md
Name: qlf_k6n10_seg_adder_pipe

Overview:
- Pipelined, carry-segmented adder/subtractor for the qlf_k6n10 arith flow.
- Splits a wide addition into SEG-bit carry-chain segments (one adder chain per segment, one segment per stage) with a registered carry between segments, so no carry chain crosses a cluster boundary.
- Sits downstream of the $alu chain mapping: consumes the same operand/BI/CI semantics and emits registered Y, X, carry-out and overflow.
- Valid/ready handshake on both sides; full throughput of one operation per cycle when not stalled.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).
- SEG, 4, segment length in bits (1 <= SEG <= WIDTH). NSEG = ceil(WIDTH/SEG); the last segment holds WIDTH-(NSEG-1)*SEG bits.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- bi  input  1  invert B (subtract when combined with ci=1).
- ci  input  1  carry into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- y  output  WIDTH  a + (bi ? ~b : b) + ci, modulo 2^WIDTH.
- x  output  WIDTH  a ^ (bi ? ~b : b).
- co  output  1  carry out of bit WIDTH-1.
- ov  output  1  signed overflow: carry into MSB xor carry out of MSB.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid=0, y=0, x=0, co=0, ov=0, all inter-segment carry registers 0.
- Reset mid-operation: all in-flight beats are discarded with no partial output. Reset dominates a simultaneous accept.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv, combinational. No state changes when adv=0; all pipeline registers hold.
- Accept: in_valid & in_ready. Stage 1 captures a, bb = bi ? ~b : b, and ci.
- Input skew: segment k (k = 0..NSEG-1) operands travel through k delay registers before being added in stage k+1.
- Stage k+1 computes segment k: {c_out, s} = a_seg + bb_seg + c_in. c_in is ci for k=0; otherwise it is the registered carry from stage k.
- Output deskew: each segment's sum is registered and carried forward so that all segments of one beat emerge together. x is carried by the same delay path.
- Latency: exactly NSEG cycles from accept to out_valid=1 when unstalled (WIDTH=16, SEG=4 gives 4). With SEG >= WIDTH, latency is 1.
- Last stage: co = carry out of the last segment's MSB. ov = carry into bit WIDTH-1 xor co, computed inside the last segment.
- Throughput: back-to-back accepts produce back-to-back outputs, in order, with no bubbles inserted.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipe and holds y/x/co/ov stable; in_ready=0.
- Bubbles: a cycle with in_valid=0 and adv=1 shifts a valid=0 slot through the pipe.
- Output update: y/x/co/ov update only when a valid result is loaded. Otherwise they hold their last value.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: one result leaves and one beat enters in the same cycle.
- Arithmetic is unsigned modulo 2^WIDTH. Subtraction a - b uses bi=1, ci=1. Signedness is reported only via ov.

Test Plan:
- WIDTH=16, SEG=4, a=16'h00FF, b=16'h0001, bi=0, ci=0, single beat -> out_valid rises exactly 4 cycles after accept; y=16'h0100, x=16'h00FE, co=0, ov=0.
- Carry across all segments: a=16'hFFFF, b=16'h0001 -> y=16'h0000, co=1, ov=0. Then a=16'h7FFF, b=16'h0001 -> y=16'h8000, co=0, ov=1.
- Subtract: a=16'h0005, b=16'h0007, bi=1, ci=1 -> y=16'hFFFE, co=0. Then a=7, b=5 -> y=16'h0002, co=1.
- Streaming with stall: 8 back-to-back random beats, out_ready low for 3 cycles mid-stream -> in_ready=0 and outputs frozen during the stall; all 8 results emerge in order and match the reference model, with no loss or duplication.
- Reset mid-flight: assert reset with 3 beats in the pipe -> next cycle out_valid=0 and y=0; no stale result ever emerges; a new beat issued after reset yields a correct result after 4 cycles.
- Ragged segmentation: WIDTH=10, SEG=4 (segments of 4, 4 and 2 bits) and WIDTH=8, SEG=8 -> latencies of 3 and 1 cycles; exhaustive 8-bit sweep matches the reference model.
